// File: rtl/seq_sub32.sv
// Sequential 32-bit subtractor: D = A - B - Bin, processed one nibble per cycle, LSB first.
// Optional signed-overflow output OVF is enabled by defining SEQ_SUB32_OVF_EN.
module seq_sub32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Bin,
  output logic [31:0] D,
  output logic        Bout,
  output logic        out_valid,
  input  logic        out_ready
`ifdef SEQ_SUB32_OVF_EN
  ,
  output logic        OVF
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [31:0] acc_q, acc_next;
  logic [31:0] d_q;
  logic        bout_q;
  logic [2:0]  cnt_q;
  logic        borrow_q;

  logic        accept;
  logic        step;
  logic        last;
  logic [4:0]  nib_lsb;
  logic [3:0]  nib_a, nib_b;
  logic [4:0]  nib_full;
  logic        nib_borrow;

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StRun;
      end
      StRun: begin
        if (cnt_q == 3'd7) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Nibble datapath: 5-bit result, bit 4 is the borrow into the next nibble
  always_comb begin
    accept     = (state_q == StIdle) && in_valid;
    step       = (state_q == StRun);
    last       = step && (cnt_q == 3'd7);
    nib_lsb    = {cnt_q, 2'b00};
    nib_a      = a_q[nib_lsb +: 4];
    nib_b      = b_q[nib_lsb +: 4];
    nib_full   = {1'b0, nib_a} - {1'b0, nib_b} - {4'b0000, borrow_q};
    nib_borrow = nib_full[4];
    acc_next   = acc_q;
    acc_next[nib_lsb +: 4] = nib_full[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      a_q      <= A;
      b_q      <= B;
      borrow_q <= Bin;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_next;
      borrow_q <= nib_borrow;
      cnt_q    <= cnt_q + 3'd1;
      if (last) begin
        d_q    <= acc_next;
        bout_q <= nib_borrow;
      end
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;

`ifdef SEQ_SUB32_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= (a_q[31] != b_q[31]) && (acc_next[31] != a_q[31]);
    end
  end

  assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_seq_sub32.sv
// Bench for seq_sub32: directed vector table, handshake/reset corner cases and random
// operations against an arithmetic reference model.
module tb_seq_sub32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic        Bin;
  logic [31:0] D;
  logic        Bout;
  logic        out_valid;
  logic        out_ready;
`ifdef SEQ_SUB32_OVF_EN
  logic        OVF;
`endif

  int checks = 0;
  int errors = 0;

  seq_sub32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .D         (D),
    .Bout      (Bout),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SEQ_SUB32_OVF_EN
    ,
    .OVF       (OVF)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the whole operands
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                       output logic [31:0] d, output logic bout, output logic ovf);
    d    = a - b - {31'd0, bin};
    bout = ({1'b0, a} < ({1'b0, b} + {32'd0, bin}));
    ovf  = (a[31] != b[31]) && (d[31] != a[31]);
  endtask

  // Starts at a negedge with the DUT idle. hold: cycles of out_ready=0 in DONE.
  // keep_valid: in_valid stays high after accept. rdy_run: out_ready level during RUN.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input logic [31:0] ed, input logic ebout, input logic eovf,
                        input int hold, input logic keep_valid, input logic rdy_run);
    int lat;
    logic [31:0] d_seen;
    logic bout_seen;
    A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = rdy_run;
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = keep_valid;
    A = $urandom; B = $urandom; Bin = 1'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      chk("in_ready_run", {63'd0, in_ready}, 64'd0);
      A = $urandom; B = $urandom;
      @(posedge clk);
      lat++;
    end
    out_ready = 1'b0;
    chk("latency", 64'(lat), 64'd8);
    chk("D", {32'd0, D}, {32'd0, ed});
    chk("Bout", {63'd0, Bout}, {63'd0, ebout});
`ifdef SEQ_SUB32_OVF_EN
    chk("OVF", {63'd0, OVF}, {63'd0, eovf});
`else
    if (eovf === 1'bx) $display("unexpected x in expected ovf");
`endif
    chk("in_ready_done", {63'd0, in_ready}, 64'd0);
    d_seen = D; bout_seen = Bout;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      A = ~A; B = ~B; Bin = ~Bin;
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      chk("hold_D", {32'd0, D}, {32'd0, d_seen});
      chk("hold_Bout", {63'd0, Bout}, {63'd0, bout_seen});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", {63'd0, out_valid}, 64'd0);
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("D_kept_in_idle", {32'd0, D}, {32'd0, d_seen});
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] ra, rb, ed;
    logic rbin, eb, eo;
    int lat;

    vecs.push_back('{32'hFFFF0000, 32'h0000FFFF, 1'b1, 32'hFFFE0000, 1'b0, 1'b0});
    vecs.push_back('{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'hFFABCEDC, 32'hEF821EDA, 1'b1, 32'h1029B001, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1});
    vecs.push_back('{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1});
    vecs.push_back('{32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{32'h00000001, 32'h00000002, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h12345678, 32'h00000001, 1'b0, 32'h12345677, 1'b0, 1'b0});

    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0; out_ready = 1'b0;
    #1;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_D", {32'd0, D}, 64'd0);
    chk("reset_Bout", {63'd0, Bout}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table; the back-pressure case holds DONE for 5 cycles
    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout, vecs[i].ovf,
             (i == 0) ? 5 : 0, (i == 0) ? 1'b1 : 1'b0, 1'b0);
    in_valid = 1'b0;

    // Reset on the 4th RUN cycle aborts the operation
    A = 32'hDEADBEEF; B = 32'h12345678; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_D", {32'd0, D}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    chk("abort_no_result", 64'(lat), 64'd0);
    run_op(32'hFFABCEDC, 32'hEF821EDA, 1'b1, 32'h1029B001, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Random back-to-back and mixed handshakes
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rbin = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      model(ra, rb, rbin, ed, eb, eo);
      run_op(ra, rb, rbin, ed, eb, eo, int'($urandom_range(0, 2)), 1'($urandom),
             1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
